// File: rtl/overture_pkg.sv
// overture_pkg: opcode/register constants and I/O decode helpers for the Overture CPU port
package overture_pkg;
  localparam logic [1:0] OPC_COPY = 2'b10;
  localparam logic [2:0] REG_IO = 3'd6;
  function automatic logic is_rd_io(input logic [7:0] instr);
    return instr[7:6] == OPC_COPY && instr[5:3] == REG_IO;
  endfunction
  function automatic logic is_wr_io(input logic [7:0] instr);
    return instr[7:6] == OPC_COPY && instr[2:0] == REG_IO;
  endfunction
endpackage

// File: rtl/overture_io_fifo.sv
// overture_io_fifo: circular-buffer FIFO with valid/ready on both sides and occupancy count
module overture_io_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign in_ready = count != (AW+1)'(DEPTH);
  assign out_valid = count != '0;
  assign out_data = mem[rd_ptr];
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/overture_io_port.sv
// overture_io_port: host<->CPU byte port; decodes I/O-register copies, stalls the CPU on
// empty input / full output, and buffers both directions in FIFOs.
module overture_io_port
  import overture_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    run_req,
  output logic                    run,
  input  logic [7:0]              instr,
  input  logic [7:0]              cpu_out,
  output logic [7:0]              cpu_in,
  input  logic                    host_in_valid,
  output logic                    host_in_ready,
  input  logic [7:0]              host_in_data,
  output logic                    host_out_valid,
  input  logic                    host_out_ready,
  output logic [7:0]              host_out_data,
  output logic [$clog2(DEPTH):0]  in_count,
  output logic [$clog2(DEPTH):0]  out_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [1:0] rst_sync;
  logic rst_int_n, rd_io, wr_io, stall, in_head_valid, out_push_ok, wr_pend;
  logic [7:0] in_head;
  // Reset asserts asynchronously but releases two edges later
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_int_n = rst_sync[1];
  assign rd_io = is_rd_io(instr);
  assign wr_io = is_wr_io(instr);
  // A pending capture already owns an output slot, so count it against capacity
  assign stall = (rd_io && !in_head_valid) || (wr_io && (out_count + CW'(wr_pend)) >= CW'(DEPTH));
  assign run = run_req && !stall && rst_int_n;
  assign cpu_in = in_head_valid ? in_head : 8'h00;
  // The CPU presents out_port one edge after the write issues
  always_ff @(posedge clk or negedge rst_int_n)
    if (!rst_int_n) wr_pend <= 1'b0;
    else wr_pend <= run && wr_io;
  overture_io_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_in_fifo (
    .clk       (clk),
    .reset_n   (rst_int_n),
    .in_valid  (host_in_valid),
    .in_ready  (host_in_ready),
    .in_data   (host_in_data),
    .out_valid (in_head_valid),
    .out_ready (run && rd_io),
    .out_data  (in_head),
    .count     (in_count)
  );
  overture_io_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_out_fifo (
    .clk       (clk),
    .reset_n   (rst_int_n),
    .in_valid  (wr_pend && out_push_ok),
    .in_ready  (out_push_ok),
    .in_data   (cpu_out),
    .out_valid (host_out_valid),
    .out_ready (host_out_ready),
    .out_data  (host_out_data),
    .count     (out_count)
  );
endmodule

// File: tb/tb_overture_io_port.sv
// tb_overture_io_port: scenario tasks with queue scoreboards for both byte streams
module tb_overture_io_port;
  localparam int DEPTH = 8;
  localparam int CW = 4;
  logic clk = 1'b0, reset_n = 1'b0, run_req = 1'b0, run;
  logic host_in_valid = 1'b0, host_in_ready, host_out_valid, host_out_ready = 1'b0;
  logic [7:0] instr = 8'h00, cpu_out = 8'h00, cpu_in, host_in_data = 8'h00, host_out_data;
  logic [CW-1:0] in_count, out_count;
  logic [7:0] in_q[$], out_q[$];
  logic [7:0] ev;
  logic exp_run, exp_ok, pend, issued;
  int checks = 0, fails = 0;

  overture_io_port #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .run_req(run_req), .run(run), .instr(instr),
    .cpu_out(cpu_out), .cpu_in(cpu_in), .host_in_valid(host_in_valid),
    .host_in_ready(host_in_ready), .host_in_data(host_in_data),
    .host_out_valid(host_out_valid), .host_out_ready(host_out_ready),
    .host_out_data(host_out_data), .in_count(in_count), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (run !== 1'b0) begin fails++; $display("FAIL reset_run got %b want 0", run); end
    checks++; if (cpu_in !== 8'h00) begin fails++; $display("FAIL reset_cpu_in got %h want 00", cpu_in); end
    checks++; if (host_in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", host_in_ready); end
    checks++; if (host_out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", host_out_valid); end
    checks++; if (in_count !== 4'd0) begin fails++; $display("FAIL reset_in_count got %0d want 0", in_count); end
    checks++; if (out_count !== 4'd0) begin fails++; $display("FAIL reset_out_count got %0d want 0", out_count); end
    @(negedge clk) reset_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_input_path;
    host_in_valid = 1'b1;
    host_in_data = 8'h11; in_q.push_back(8'h11); tick();
    host_in_data = 8'h22; in_q.push_back(8'h22); tick();
    host_in_valid = 1'b0;
    checks++; if (in_count !== 4'd2) begin fails++; $display("FAIL in_count_2 got %0d want 2", in_count); end
    instr = 8'hB0; run_req = 1'b1; #1;
    for (int i = 0; i < 2; i++) begin
      ev = in_q.pop_front();
      checks++; if (run !== 1'b1) begin fails++; $display("FAIL rd_run[%0d] got %b want 1", i, run); end
      checks++; if (cpu_in !== ev) begin fails++; $display("FAIL rd_cpu_in[%0d] got %h want %h", i, cpu_in, ev); end
      tick();
      checks++; if (in_count !== CW'(1 - i)) begin fails++; $display("FAIL rd_in_count[%0d] got %0d want %0d", i, in_count, 1 - i); end
    end
    checks++; if (run !== 1'b0) begin fails++; $display("FAIL rd_empty_run got %b want 0", run); end
    checks++; if (cpu_in !== 8'h00) begin fails++; $display("FAIL rd_empty_cpu_in got %h want 00", cpu_in); end
    run_req = 1'b0; instr = 8'h00;
  endtask

  task automatic test_stall_input;
    instr = 8'hB0; run_req = 1'b1; #1;
    checks++; if (run !== 1'b0) begin fails++; $display("FAIL stall_in_run got %b want 0", run); end
    tick();
    checks++; if (run !== 1'b0 || in_count !== 4'd0) begin fails++; $display("FAIL stall_in_hold run %b count %0d want 0 0", run, in_count); end
    host_in_valid = 1'b1; host_in_data = 8'h5A; in_q.push_back(8'h5A);
    tick();
    host_in_valid = 1'b0; #1;
    ev = in_q.pop_front();
    checks++; if (run !== 1'b1) begin fails++; $display("FAIL stall_in_release got %b want 1", run); end
    checks++; if (cpu_in !== ev) begin fails++; $display("FAIL stall_in_data got %h want %h", cpu_in, ev); end
    tick();
    checks++; if (in_count !== 4'd0) begin fails++; $display("FAIL stall_in_pop got %0d want 0", in_count); end
    run_req = 1'b0; instr = 8'h00;
  endtask

  task automatic test_output;
    host_out_ready = 1'b0; instr = 8'h86; run_req = 1'b1; #1;
    checks++; if (run !== 1'b1) begin fails++; $display("FAIL wr_run got %b want 1", run); end
    tick();
    instr = 8'h00; run_req = 1'b0; cpu_out = 8'h3C; out_q.push_back(8'h3C); #1;
    checks++; if (out_count !== 4'd0 || host_out_valid !== 1'b0) begin fails++; $display("FAIL wr_early count %0d valid %b want 0 0", out_count, host_out_valid); end
    tick();
    checks++; if (out_count !== 4'd1 || host_out_valid !== 1'b1) begin fails++; $display("FAIL wr_landed count %0d valid %b want 1 1", out_count, host_out_valid); end
    ev = out_q.pop_front();
    checks++; if (host_out_data !== ev) begin fails++; $display("FAIL wr_data got %h want %h", host_out_data, ev); end
    host_out_ready = 1'b1; tick(); host_out_ready = 1'b0;
    checks++; if (out_count !== 4'd0) begin fails++; $display("FAIL wr_pop got %0d want 0", out_count); end
  endtask

  task automatic drain_out(input string tag);
    host_out_ready = 1'b1;
    for (int k = 0; k < 40 && out_q.size() > 0; k++) begin
      if (host_out_valid) begin
        ev = out_q.pop_front();
        checks++; if (host_out_data !== ev) begin fails++; $display("FAIL %s_drain got %h want %h", tag, host_out_data, ev); end
      end
      tick();
    end
    host_out_ready = 1'b0;
    checks++; if (out_q.size() != 0 || out_count !== 4'd0) begin fails++; $display("FAIL %s_drain_end left %0d count %0d want 0 0", tag, out_q.size(), out_count); end
  endtask

  task automatic test_out_full;
    host_out_ready = 1'b0; instr = 8'h86; run_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      checks++; if (run !== 1'b1) begin fails++; $display("FAIL full_wr_run[%0d] got %b want 1", i, run); end
      tick();
      cpu_out = 8'(160 + i); out_q.push_back(8'(160 + i));
    end
    #1;
    checks++; if (run !== 1'b0) begin fails++; $display("FAIL full_ninth_run got %b want 0", run); end
    tick();
    checks++; if (out_count !== 4'd8 || run !== 1'b0) begin fails++; $display("FAIL full_count count %0d run %b want 8 0", out_count, run); end
    host_out_ready = 1'b1; #1;
    ev = out_q.pop_front();
    checks++; if (host_out_data !== ev) begin fails++; $display("FAIL full_pop_data got %h want %h", host_out_data, ev); end
    tick(); host_out_ready = 1'b0; #1;
    checks++; if (out_count !== 4'd7 || run !== 1'b1) begin fails++; $display("FAIL full_release count %0d run %b want 7 1", out_count, run); end
    tick();
    instr = 8'h00; run_req = 1'b0; cpu_out = 8'hC9; out_q.push_back(8'hC9);
    tick();
    checks++; if (out_count !== 4'd8) begin fails++; $display("FAIL full_refill got %0d want 8", out_count); end
    drain_out("full");
  endtask

  task automatic test_echo;
    host_in_valid = 1'b1; host_in_data = 8'h77; in_q.push_back(8'h77);
    tick();
    host_in_valid = 1'b0; instr = 8'hB6; run_req = 1'b1; #1;
    ev = in_q.pop_front();
    checks++; if (run !== 1'b1) begin fails++; $display("FAIL echo_run got %b want 1", run); end
    checks++; if (cpu_in !== ev) begin fails++; $display("FAIL echo_cpu_in got %h want %h", cpu_in, ev); end
    tick();
    instr = 8'h00; run_req = 1'b0; cpu_out = 8'h77; out_q.push_back(8'h77);
    checks++; if (in_count !== 4'd0) begin fails++; $display("FAIL echo_in_count got %0d want 0", in_count); end
    tick();
    checks++; if (out_count !== 4'd1) begin fails++; $display("FAIL echo_out_count got %0d want 1", out_count); end
    drain_out("echo");
  endtask

  task automatic test_back_to_back;
    instr = 8'hB0;
    for (int i = 0; i < 60; i++) begin
      host_in_valid = (i < 30) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 3);
      host_in_data = 8'($urandom);
      run_req = (i < 30) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 4) != 0);
      #1;
      exp_run = run_req && in_q.size() != 0;
      exp_ok = in_q.size() < DEPTH;
      checks++; if (run !== exp_run) begin fails++; $display("FAIL b2b_run[%0d] got %b want %b", i, run, exp_run); end
      checks++; if (host_in_ready !== exp_ok) begin fails++; $display("FAIL b2b_ready[%0d] got %b want %b", i, host_in_ready, exp_ok); end
      if (run && in_q.size() != 0) begin
        ev = in_q.pop_front();
        checks++; if (cpu_in !== ev) begin fails++; $display("FAIL b2b_data[%0d] got %h want %h", i, cpu_in, ev); end
      end
      if (host_in_valid && host_in_ready) in_q.push_back(host_in_data);
      tick();
      checks++; if (int'(in_count) !== in_q.size()) begin fails++; $display("FAIL b2b_count[%0d] got %0d want %0d", i, in_count, in_q.size()); end
    end
    host_in_valid = 1'b0; run_req = 1'b1;
    for (int k = 0; k < 40 && in_q.size() > 0; k++) begin
      #1;
      if (run) begin
        ev = in_q.pop_front();
        checks++; if (cpu_in !== ev) begin fails++; $display("FAIL b2b_drain got %h want %h", cpu_in, ev); end
      end
      tick();
    end
    run_req = 1'b0; instr = 8'h00;
    checks++; if (in_q.size() != 0 || in_count !== 4'd0) begin fails++; $display("FAIL b2b_drain_end left %0d count %0d want 0 0", in_q.size(), in_count); end
  endtask

  task automatic test_stream_out;
    pend = 1'b0; instr = 8'h86;
    for (int i = 0; i < 60; i++) begin
      if (pend) begin cpu_out = 8'($urandom); out_q.push_back(cpu_out); end
      run_req = ($urandom_range(0, 3) != 0);
      host_out_ready = (i < 30) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      #1;
      exp_run = run_req && out_q.size() < DEPTH;
      exp_ok = (out_q.size() - int'(pend)) > 0;
      checks++; if (run !== exp_run) begin fails++; $display("FAIL so_run[%0d] got %b want %b", i, run, exp_run); end
      checks++; if (host_out_valid !== exp_ok) begin fails++; $display("FAIL so_valid[%0d] got %b want %b", i, host_out_valid, exp_ok); end
      issued = run;
      if (host_out_valid && host_out_ready && out_q.size() != 0) begin
        ev = out_q.pop_front();
        checks++; if (host_out_data !== ev) begin fails++; $display("FAIL so_data[%0d] got %h want %h", i, host_out_data, ev); end
      end
      tick();
      pend = issued;
      checks++; if (int'(out_count) !== out_q.size()) begin fails++; $display("FAIL so_count[%0d] got %0d want %0d", i, out_count, out_q.size()); end
    end
    instr = 8'h00; run_req = 1'b0; host_out_ready = 1'b0;
    if (pend) begin cpu_out = 8'($urandom); out_q.push_back(cpu_out); end
    tick();
    drain_out("so");
  endtask

  task automatic test_reset_mid;
    host_in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin host_in_data = 8'(i); tick(); end
    host_in_valid = 1'b0;
    checks++; if (in_count !== 4'd3) begin fails++; $display("FAIL rm_in_count got %0d want 3", in_count); end
    instr = 8'h86; run_req = 1'b1;
    tick();
    instr = 8'h00; run_req = 1'b0; cpu_out = 8'hEE;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (in_count !== 4'd0 || out_count !== 4'd0) begin fails++; $display("FAIL rm_counts in %0d out %0d want 0 0", in_count, out_count); end
    checks++; if (host_out_valid !== 1'b0 || cpu_in !== 8'h00) begin fails++; $display("FAIL rm_outputs valid %b cpu_in %h want 0 00", host_out_valid, cpu_in); end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (4) tick();
    checks++; if (out_count !== 4'd0 || host_out_valid !== 1'b0) begin fails++; $display("FAIL rm_no_capture count %0d valid %b want 0 0", out_count, host_out_valid); end
    checks++; if (in_count !== 4'd0 || host_in_ready !== 1'b1) begin fails++; $display("FAIL rm_in_after count %0d ready %b want 0 1", in_count, host_in_ready); end
  endtask

  initial begin
    test_reset();
    test_input_path();
    test_stall_input();
    test_output();
    test_out_full();
    test_echo();
    test_back_to_back();
    test_stream_out();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/overture_io_port.md
OVERTURE_IO_PORT -- requirements
Module: overture_io_port

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the entries per FIFO (power of two, 2..64).
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Port run_req  input  1  SHALL be the host request for the CPU to execute.
REQ-005 Port run  output  1  SHALL be the gated run driven to the CPU.
REQ-006 Port instr  input  8  SHALL be the CPU's current instruction (instr_debug).
REQ-007 Port cpu_out  input  8  SHALL be the CPU's out_port.
REQ-008 Port cpu_in  output  8  SHALL be the CPU's in_port.
REQ-009 Ports host_in_valid/host_in_ready  in/out  1/1, host_in_data  input  8  SHALL form the host-to-CPU byte stream.
REQ-010 Ports host_out_valid/host_out_ready  out/in  1/1, host_out_data  output  8  SHALL form the CPU-to-host byte stream.
REQ-011 Ports in_count, out_count  output  $clog2(DEPTH)+1  SHALL report FIFO occupancy.

Function
REQ-012 Decode: copy = instr[7:6]==2'b10; rd_io = copy && instr[5:3]==3'd6; wr_io = copy && instr[2:0]==3'd6; copy 6->6 SHALL assert both.
REQ-013 cpu_in SHALL equal the input FIFO head combinationally; 8'h00 when empty.
REQ-014 stall = (rd_io && in_empty) || (wr_io && (out_count + wr_pend) >= DEPTH); run = run_req && !stall.
REQ-015 Input pop SHALL occur at the edge where run && rd_io; no pop when run is low.
REQ-016 wr_pend SHALL be set at the edge where run && wr_io and cleared the following edge.
REQ-017 With wr_pend=1, the edge SHALL push cpu_out (the value the CPU wrote on the prior edge) into the output FIFO.
REQ-018 Host push SHALL occur when host_in_valid && host_in_ready; host_in_ready = !in_full.
REQ-019 host_out_valid = !out_empty, host_out_data = output head; pop when host_out_valid && host_out_ready.
REQ-020 Simultaneous push and pop on the same FIFO SHALL both take effect; count unchanged; push when full is only legal alongside a pop.
REQ-021 Pointers SHALL wrap modulo DEPTH; count range 0..DEPTH; no data loss or duplication at wrap.
REQ-022 Stall SHALL resolve without host action only by host push (input) or host pop (output); run stays low meanwhile.
REQ-023 FIFO order SHALL be strictly first-in first-out on both paths.

Reset
REQ-024 reset_n low SHALL asynchronously clear pointers, counts, wr_pend; outputs: run=0 (until run_req), cpu_in=8'h00, host_in_ready=1, host_out_valid=0, counts=0.
REQ-025 Reset mid-operation SHALL discard all queued bytes and any pending output capture.
REQ-026 Release SHALL be synchronised internally (two-flop deassertion); first update on the second edge after release.

Structure
REQ-027 Package overture_pkg SHALL hold OPC_COPY=2'b10, REG_IO=3'd6 and the decode functions is_rd_io/is_wr_io.
REQ-028 Sub-module overture_io_fifo (parameter DEPTH, WIDTH=8, valid/ready both sides, count output) SHALL be instantiated twice.
REQ-029 The gated run and decode SHALL remain combinational; no extra CPU latency when FIFOs permit.

Verification
REQ-030 Push 8'h11,8'h22; instr=8'hB0 (copy r6->r0) two cycles with run_req=1 -> cpu_in 8'h11 then 8'h22, in_count 2->1->0.
REQ-031 Input empty, instr=8'hB0, run_req=1 -> run=0; push 8'h5A -> run=1 same cycle, pop at next edge.
REQ-032 instr=8'h86 (copy r0->r6), cpu_out=8'h3C next cycle -> host_out_data=8'h3C, out_count=1 two edges after issue.
REQ-033 DEPTH=8, host_out_ready=0, 8 writes -> out_count=8, run=0 on ninth wr_io; one host pop -> run=1.
REQ-034 instr=8'hB6 with input 8'h77 and CPU echoing -> pop input and push 8'h77 to output.
REQ-035 reset_n low with in_count=3, wr_pend=1 -> counts 0, host_out_valid=0, no capture after release.
